// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store initiator for a byte-addressed memory with a registered read port.
module load_store_unit #(
  parameter int ADDR_W = 16,
  parameter int MEM_SIZE = 65536,
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_we,
  input  logic [2:0]        i_req_funct3,
  input  logic [31:0]       i_req_addr,
  input  logic [31:0]       i_req_wdata,
  input  logic [4:0]        i_req_rd,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [31:0]       o_rsp_rdata,
  output logic [4:0]        o_rsp_rd,
  output logic              o_rsp_err,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  output logic [3:0]        o_mem_bmask,
  output logic              o_mem_wren,
  input  logic [31:0]       i_mem_rdata
);
  typedef enum logic [2:0] {IDLE, ST, LD_ADDR, LD_DATA, RESP} state_t;
  state_t state, state_nx;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0] wdata_q, rdata_q, ld_fmt;
  logic [2:0] funct3_q, n;
  logic [4:0] rd_q;
  logic err_q, legal, range_err, mis, req_err, accept;
  logic [32:0] last;
  // Request decode; the end address is formed in 33 bits so a request near 2^32 cannot wrap into range.
  always_comb begin
    n = i_req_funct3[1] ? 3'd4 : i_req_funct3[0] ? 3'd2 : 3'd1;
    legal = i_req_we ? (i_req_funct3 <= 3'd2) : (i_req_funct3 != 3'd3 && i_req_funct3[2:1] != 2'b11);
    last = {1'b0, i_req_addr} + {30'd0, n} - 33'd1;
    range_err = last >= 33'(MEM_SIZE);
    mis = !ALLOW_MISALIGNED && ((n == 3'd2 && i_req_addr[0]) || (n == 3'd4 && i_req_addr[1:0] != 2'b00));
    req_err = !legal || range_err || mis;
  end
  assign accept = i_req_valid && o_req_ready;
  assign ld_fmt = funct3_q[1] ? i_mem_rdata
                : funct3_q[0] ? {{16{~funct3_q[2] & i_mem_rdata[15]}}, i_mem_rdata[15:0]}
                :               {{24{~funct3_q[2] & i_mem_rdata[7]}}, i_mem_rdata[7:0]};
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = req_err ? RESP : i_req_we ? ST : LD_ADDR;
      ST:      state_nx = RESP;
      LD_ADDR: state_nx = LD_DATA;
      LD_DATA: state_nx = RESP;
      RESP:    if (i_rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state <= IDLE;
      addr_q <= '0;
      wdata_q <= '0;
      funct3_q <= '0;
      rd_q <= '0;
      rdata_q <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        addr_q <= i_req_addr[ADDR_W-1:0];
        wdata_q <= i_req_wdata;
        funct3_q <= i_req_funct3;
        rd_q <= i_req_rd;
        rdata_q <= '0;
        err_q <= req_err;
      end
      if (state == LD_DATA) rdata_q <= ld_fmt;
    end
  end
  assign o_req_ready = state == IDLE && i_reset;
  assign o_rsp_valid = state == RESP;
  assign o_rsp_rdata = rdata_q;
  assign o_rsp_rd = rd_q;
  assign o_rsp_err = err_q;
  assign o_mem_addr = addr_q;
  assign o_mem_wdata = wdata_q;
  assign o_mem_wren = state == ST;
  assign o_mem_bmask = state != ST ? 4'h0 : funct3_q[1] ? 4'hf : funct3_q[0] ? 4'h3 : 4'h1;
endmodule
